// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker: a shared phase accumulator drives per-channel wrap dividers and a half-period green toggle.
// Optional macro LED_BLINK_PWM_EN adds a DUTY input that PWM-dims all LED outputs.
module led_blink_multi #(
    parameter int CHANNELS  = 4,
    parameter int SEL_W     = 4,
    parameter int CNT_W     = 32,
    parameter int PERIOD    = 50000000,
    parameter int STEP_UNIT = 10
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic [SEL_W-1:0]    SW,
    input  logic [CHANNELS-1:0] CH_EN,
`ifdef LED_BLINK_PWM_EN
    input  logic [3:0]          DUTY,
`endif
    output logic [CHANNELS-1:0] LEDR,
    output logic                LEDG
);

    localparam int WC_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_W:0] PERIOD_X = (CNT_W+1)'(PERIOD);
    localparam logic [CNT_W:0] HALF_X   = (CNT_W+1)'(PERIOD / 2);

    // The largest step must stay below half a period so a wrap and a half-crossing never coincide.
    if (STEP_UNIT * SEL_W >= PERIOD / 2) begin : g_chk_step
        $error("led_blink_multi: STEP_UNIT*SEL_W must be below PERIOD/2");
    end
    if ((longint'(PERIOD) - 1 + longint'(STEP_UNIT) * SEL_W) >= (longint'(1) << CNT_W)) begin : g_chk_width
        $error("led_blink_multi: CNT_W too narrow for PERIOD plus largest step");
    end

    logic [CNT_W-1:0]    acc;
    logic [CNT_W-1:0]    step;
    logic [CNT_W-1:0]    sel_step;
    logic [CNT_W:0]      sum;
    logic                wrap;
    logic                half_cross;
    logic [CHANNELS-1:0] led_q;
    logic                ledg_q;
    logic [WC_W-1:0]     wrap_cnt [CHANNELS];

    // Ascending scan: the highest set switch bit is the last to assign and therefore wins.
    always_comb begin
        sel_step = CNT_W'(1);
        for (int k = 0; k < SEL_W; k++) begin
            if (SW[k]) sel_step = CNT_W'(STEP_UNIT * (k + 1));
        end
    end

    assign sum        = {1'b0, acc} + {1'b0, step};
    assign wrap       = (sum >= PERIOD_X);
    assign half_cross = ({1'b0, acc} < HALF_X) && (sum >= HALF_X);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            acc    <= '0;
            step   <= CNT_W'(1);
            ledg_q <= 1'b0;
        end else begin
            if (wrap) begin
                // Keep the overshoot so no phase is lost; speed changes only land here.
                acc  <= CNT_W'(sum - PERIOD_X);
                step <= sel_step;
            end else begin
                acc  <= sum[CNT_W-1:0];
            end
            if (half_cross) ledg_q <= ~ledg_q;
        end
    end

    // Channel i toggles on every (i+1)-th wrap; disabling clears both the count and the LED.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            led_q <= '0;
            for (int i = 0; i < CHANNELS; i++) wrap_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!CH_EN[i]) begin
                    wrap_cnt[i] <= '0;
                    led_q[i]    <= 1'b0;
                end else if (wrap) begin
                    if (wrap_cnt[i] == WC_W'(i)) begin
                        wrap_cnt[i] <= '0;
                        led_q[i]    <= ~led_q[i];
                    end else begin
                        wrap_cnt[i] <= wrap_cnt[i] + WC_W'(1);
                    end
                end
            end
        end
    end

`ifdef LED_BLINK_PWM_EN
    logic [3:0] pwm_cnt;
    logic       pwm_on;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) pwm_cnt <= 4'd0;
        else       pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign pwm_on = (pwm_cnt < DUTY);
    assign LEDR   = led_q & {CHANNELS{pwm_on}};
    assign LEDG   = ledg_q & pwm_on;
`else
    assign LEDR = led_q;
    assign LEDG = ledg_q;
`endif

endmodule

// File: tb/tb_led_blink_multi.sv
// Bench for led_blink_multi (small PERIOD): timing table, hand-written corner sequences and random stimulus vs. a phase model.
module tb_led_blink_multi;

    localparam int CHANNELS  = 4;
    localparam int SEL_W     = 4;
    localparam int CNT_W     = 32;
    localparam int PERIOD    = 100;
    localparam int STEP_UNIT = 10;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [SEL_W-1:0]    sw  = '0;
    logic [CHANNELS-1:0] en  = '1;
    logic [CHANNELS-1:0] ledr;
    logic                ledg;

    always #5 clk = ~clk;

    led_blink_multi #(
        .CHANNELS(CHANNELS), .SEL_W(SEL_W), .CNT_W(CNT_W),
        .PERIOD(PERIOD), .STEP_UNIT(STEP_UNIT)
    ) dut (
        .CLOCK_50(clk),
        .RESET(rst),
        .SW(sw),
        .CH_EN(en),
        .LEDR(ledr),
        .LEDG(ledg)
    );

    // Reference model: phase position, crossing count and wraps seen since each channel was enabled.
    int m_acc;
    int m_step;
    int m_half;
    int m_wrap_total;
    int m_wraps [CHANNELS];

    logic [CHANNELS:0] exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int                  cycles;
        logic [SEL_W-1:0]    sw;
        logic [CHANNELS-1:0] en;
        logic [CHANNELS-1:0] ledr;
        logic                ledg;
    } vec_t;
    vec_t tbl [15];

    function automatic int speed_of(logic [SEL_W-1:0] s);
        for (int k = SEL_W - 1; k >= 0; k--) begin
            if (s[k]) return STEP_UNIT * (k + 1);
        end
        return 1;
    endfunction

    function automatic logic [CHANNELS-1:0] model_ledr();
        logic [CHANNELS-1:0] r;
        for (int i = 0; i < CHANNELS; i++) r[i] = ((m_wraps[i] / (i + 1)) % 2) != 0;
        return r;
    endfunction

    task automatic model_reset();
        m_acc = 0;
        m_step = 1;
        m_half = 0;
        m_wrap_total = 0;
        for (int i = 0; i < CHANNELS; i++) m_wraps[i] = 0;
    endtask

    task automatic model_edge();
        int  total;
        bit  wrapped;
        total = m_acc + m_step;
        if (m_acc < PERIOD / 2 && total >= PERIOD / 2) m_half++;
        wrapped = (total >= PERIOD);
        if (wrapped) begin
            m_acc = total - PERIOD;
            m_step = speed_of(sw);
            m_wrap_total++;
        end else begin
            m_acc = total;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (!en[i]) m_wraps[i] = 0;
            else if (wrapped) m_wraps[i]++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [CHANNELS:0] exp;
        @(posedge clk);
        model_edge();
        exp_q.push_back({model_ledr(), (m_half % 2) != 0});
        #1;
        exp = exp_q.pop_front();
        check("model_out", 32'({ledr, ledg}), 32'(exp));
        check("model_acc", dut.acc, 32'(m_acc));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_ledr", 32'(ledr), 32'd0);
        check("rst_ledg", 32'(ledg), 32'd0);
        check("rst_acc", dut.acc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_table();
        for (int i = 0; i < 15; i++) begin
            sw = tbl[i].sw;
            en = tbl[i].en;
            repeat (tbl[i].cycles) tick();
            check("tbl_ledr", 32'(ledr), 32'(tbl[i].ledr));
            check("tbl_ledg", 32'(ledg), 32'(tbl[i].ledg));
        end
    endtask

    initial begin
        int exp3 [7];
        int exp4 [5];
        int w0;
        bit seen;

        // Edges 49,50,99,100,149,150,199,200,300..900 after reset with SW=0.
        tbl[0]  = '{49,  4'h0, 4'hF, 4'b0000, 1'b0};
        tbl[1]  = '{1,   4'h0, 4'hF, 4'b0000, 1'b1};
        tbl[2]  = '{49,  4'h0, 4'hF, 4'b0000, 1'b1};
        tbl[3]  = '{1,   4'h0, 4'hF, 4'b0001, 1'b1};
        tbl[4]  = '{49,  4'h0, 4'hF, 4'b0001, 1'b1};
        tbl[5]  = '{1,   4'h0, 4'hF, 4'b0001, 1'b0};
        tbl[6]  = '{49,  4'h0, 4'hF, 4'b0001, 1'b0};
        tbl[7]  = '{1,   4'h0, 4'hF, 4'b0010, 1'b0};
        tbl[8]  = '{100, 4'h0, 4'hF, 4'b0111, 1'b1};
        tbl[9]  = '{100, 4'h0, 4'hF, 4'b1100, 1'b0};
        tbl[10] = '{100, 4'h0, 4'hF, 4'b1101, 1'b1};
        tbl[11] = '{100, 4'h0, 4'hF, 4'b1010, 1'b0};
        tbl[12] = '{100, 4'h0, 4'hF, 4'b1011, 1'b1};
        tbl[13] = '{100, 4'h0, 4'hF, 4'b0000, 1'b0};
        tbl[14] = '{100, 4'h0, 4'hF, 4'b0101, 1'b1};
        exp3 = '{30, 60, 90, 20, 50, 80, 10};
        exp4 = '{40, 80, 20, 60, 0};

        model_reset();
        sw = '0;
        en = '1;
        do_reset();
        run_table();

        // Asynchronous reset between edges, mid-period, with LEDR=0101.
        repeat (50) tick();
        check("pre_rst_ledr", 32'(ledr), 32'b0101);
        rst = 1'b1;
        model_reset();
        #2;
        check("async_ledr", 32'(ledr), 32'd0);
        check("async_ledg", 32'(ledg), 32'd0);
        check("async_acc", dut.acc, 32'd0);
        #2;
        rst = 1'b0;
        run_table();

        // SW=0001 held from reset: step 1 until the first wrap, then 10.
        sw = 4'b0001;
        do_reset();
        repeat (100) tick();
        check("s2_acc100", dut.acc, 32'd0);
        repeat (4) tick();
        check("s2_ledg104", 32'(ledg), 32'd1);
        tick();
        check("s2_ledg105", 32'(ledg), 32'd0);
        repeat (5) tick();
        check("s2_ledr110", 32'(ledr), 32'b0010);
        check("s2_acc110", dut.acc, 32'd0);

        // SW=0110 applied before the first wrap -> step 30 afterwards.
        sw = 4'b0000;
        do_reset();
        repeat (99) tick();
        sw = 4'b0110;
        tick();
        for (int j = 0; j < 7; j++) begin
            tick();
            check("s3_acc", dut.acc, 32'(exp3[j]));
        end

        // SW=1000 -> step 40, remainder carried across wraps.
        sw = 4'b1000;
        do_reset();
        repeat (100) tick();
        for (int j = 0; j < 5; j++) begin
            tick();
            check("s4_acc", dut.acc, 32'(exp4[j]));
        end

        // Channel 2 disabled for 8 wraps, then re-enabled.
        en = 4'b1011;
        for (int j = 0; j < 20; j++) begin
            tick();
            check("s5_off", 32'(ledr[2]), 32'd0);
        end
        en = 4'hF;
        w0 = m_wrap_total;
        seen = 1'b0;
        for (int j = 0; j < 100 && !seen; j++) begin
            tick();
            if (ledr[2]) seen = 1'b1;
        end
        check("s5_seen", 32'(seen), 32'd1);
        check("s5_wraps", 32'(m_wrap_total - w0), 32'd3);

        // Random switches and enables against the model.
        do_reset();
        for (int j = 0; j < 3000; j++) begin
            if ($urandom_range(0, 49) == 0) sw = SEL_W'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) en = CHANNELS'($urandom_range(0, 15));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
